// File: rtl/instruction_fetch_register.sv
// Instruction register: assembles NUM_BYTES bytes of BYTE_W bits from a byte stream into one instruction.
// Latency: a byte is registered at its transfer edge; o_ir_valid rises the cycle after the completing byte.
// Backpressure: o_iready comes from registered state only. It is low while a complete instruction waits for i_consume.
//
// Optional macro IR_PREFETCH_EN: adds a shadow buffer. The shadow keeps accepting bytes while a complete
// instruction waits, so the next instruction can be handed over with no o_ir_valid gap.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_i          fetched byte
//   i_ivalid     i_i is valid this cycle
//   o_iready     block can accept a byte
//   i_mode       0 = sequential placement (lowest empty slot), 1 = indexed placement (i_byte_sel)
//   i_byte_sel   target byte index when i_mode = 1
//   i_consume    decoder has taken the instruction
//   i_flush      discard the partial or complete instruction (highest priority)
//   o_ir_out     assembled instruction; byte 0 is least significant
//   o_ir_valid   o_ir_out holds a complete instruction
//   o_byte_count number of distinct bytes loaded in the primary buffer
module instruction_fetch_register #(
  parameter  int BYTE_W    = 8,
  parameter  int NUM_BYTES = 2,
  localparam int IDX_W     = $clog2(NUM_BYTES)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [BYTE_W-1:0]           i_i,
  input  logic                        i_ivalid,
  output logic                        o_iready,
  input  logic                        i_mode,
  input  logic [IDX_W-1:0]            i_byte_sel,
  input  logic                        i_consume,
  input  logic                        i_flush,
  output logic [BYTE_W*NUM_BYTES-1:0] o_ir_out,
  output logic                        o_ir_valid,
  output logic [IDX_W:0]              o_byte_count
);

  typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

  localparam logic [NUM_BYTES-1:0] ALL_ONES = '1;
  localparam logic [IDX_W:0]       CNT_FULL = (IDX_W+1)'(NUM_BYTES);

  // One bit per encodable i_byte_sel value. A bit is set when that index is a real byte slot.
  function automatic logic [(1<<IDX_W)-1:0] idx_valid_vec();
    logic [(1<<IDX_W)-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_BYTES; k++) v[k] = 1'b1;
    return v;
  endfunction

  localparam logic [(1<<IDX_W)-1:0] IDX_OK = idx_valid_vec();

  function automatic logic [IDX_W:0] popcount(input logic [NUM_BYTES-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int k = 0; k < NUM_BYTES; k++) c = c + {{IDX_W{1'b0}}, m[k]};
    return c;
  endfunction

  state_t                           r_state;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] r_ir;
  logic [NUM_BYTES-1:0]             r_mask;
  logic                             r_valid;
  logic [IDX_W:0]                   r_count;

`ifdef IR_PREFETCH_EN
  logic [NUM_BYTES-1:0][BYTE_W-1:0] r_sh;
  logic [NUM_BYTES-1:0]             r_sh_mask;
`endif

  logic                 w_iready;
  logic [NUM_BYTES-1:0] w_tgt_mask;   // mask that governs placement in the current state
  logic                 w_seq_hit;
  logic [IDX_W-1:0]     w_seq_idx;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_idx_ok;
  logic                 w_wr;
  logic [NUM_BYTES-1:0] w_onehot;
  logic [NUM_BYTES-1:0] w_mask_nxt;

`ifdef IR_PREFETCH_EN
  // While FULL, bytes go to the shadow, so the shadow mask drives ready and placement.
  assign w_iready   = (r_state == ST_FILL) || (r_sh_mask != ALL_ONES);
  assign w_tgt_mask = (r_state == ST_FULL) ? r_sh_mask : r_mask;
`else
  assign w_iready   = (r_state == ST_FILL);
  assign w_tgt_mask = r_mask;
`endif

  always_comb begin
    w_seq_hit = 1'b0;
    w_seq_idx = '0;
    // Scan downward so that the last match is the lowest empty slot.
    for (int k = NUM_BYTES - 1; k >= 0; k--) begin
      if (!w_tgt_mask[k]) begin
        w_seq_hit = 1'b1;
        w_seq_idx = IDX_W'(k);
      end
    end
    if (i_mode) begin
      w_idx    = i_byte_sel;
      w_idx_ok = IDX_OK[i_byte_sel];
    end else begin
      w_idx    = w_seq_idx;
      w_idx_ok = w_seq_hit;
    end
    // An out-of-range index is still accepted (ready is unaffected) but writes nothing.
    w_wr     = i_ivalid && w_iready && w_idx_ok;
    w_onehot = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      w_onehot[k] = w_wr && (w_idx == IDX_W'(k));
    end
    w_mask_nxt = w_tgt_mask | w_onehot;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_FILL;
      r_ir      <= '0;
      r_mask    <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
`ifdef IR_PREFETCH_EN
      r_sh      <= '0;
      r_sh_mask <= '0;
`endif
    end else if (i_flush) begin
      // The instruction bytes are left in place; only the bookkeeping is cleared.
      r_state   <= ST_FILL;
      r_mask    <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
`ifdef IR_PREFETCH_EN
      r_sh_mask <= '0;
`endif
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_wr) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (w_onehot[k]) r_ir[k] <= i_i;
            end
            r_mask  <= w_mask_nxt;
            r_count <= popcount(w_mask_nxt);
            if (w_mask_nxt == ALL_ONES) begin
              r_state <= ST_FULL;
              r_valid <= 1'b1;
            end
          end
        end
        ST_FULL: begin
`ifdef IR_PREFETCH_EN
          if (i_consume) begin
            // Hand over the shadow. A byte arriving at this same edge is merged in.
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (w_mask_nxt[k]) r_ir[k] <= w_onehot[k] ? i_i : r_sh[k];
            end
            r_mask    <= w_mask_nxt;
            r_count   <= popcount(w_mask_nxt);
            r_sh_mask <= '0;
            if (w_mask_nxt != ALL_ONES) begin
              r_state <= ST_FILL;
              r_valid <= 1'b0;
            end
          end else if (w_wr) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (w_onehot[k]) r_sh[k] <= i_i;
            end
            r_sh_mask <= w_mask_nxt;
          end
`else
          if (i_consume) begin
            r_state <= ST_FILL;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_count <= '0;
          end
`endif
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign o_iready     = w_iready;
  assign o_ir_out     = r_ir;
  assign o_ir_valid   = r_valid;
  assign o_byte_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_register.sv
module tb_instruction_fetch_register;

`ifdef IR_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d;
  logic        mode, consume, flush;
  logic        sel2;
  logic [1:0]  sel4;
  logic        v2, v4;
  logic        rdy2, val2, rdy4, val4;
  logic [15:0] ir2;
  logic [31:0] ir4;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_register #(.BYTE_W(8), .NUM_BYTES(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_i(d), .i_ivalid(v2), .o_iready(rdy2),
    .i_mode(mode), .i_byte_sel(sel2), .i_consume(consume), .i_flush(flush),
    .o_ir_out(ir2), .o_ir_valid(val2), .o_byte_count(cnt2)
  );

  instruction_fetch_register #(.BYTE_W(8), .NUM_BYTES(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_i(d), .i_ivalid(v4), .o_iready(rdy4),
    .i_mode(mode), .i_byte_sel(sel4), .i_consume(consume), .i_flush(flush),
    .o_ir_out(ir4), .o_ir_valid(val4), .o_byte_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; d = '0; mode = 1'b0; consume = 1'b0; flush = 1'b0;
    sel2 = 1'b0; sel4 = '0; v2 = 1'b0; v4 = 1'b0;

    // Reset state (before any clock edge)
    #2;
    chk("rst_ir2",   32'(ir2),  32'h0);
    chk("rst_val2",  32'(val2), 32'h0);
    chk("rst_cnt2",  32'(cnt2), 32'h0);
    chk("rst_rdy2",  32'(rdy2), 32'h1);
    chk("rst_ir4",   32'(ir4),  32'h0);
    #1 rst_n = 1'b1;
    tick();

    // Sequential fill of a 2-byte instruction
    v2 = 1'b1; d = 8'h12;
    tick();
    chk("seq_cnt1",  32'(cnt2), 32'h1);
    chk("seq_val1",  32'(val2), 32'h0);
    chk("seq_rdy1",  32'(rdy2), 32'h1);
    d = 8'h34;
    tick();
    chk("seq_ir",    32'(ir2),  32'h3412);
    chk("seq_val2",  32'(val2), 32'h1);
    chk("seq_cnt2",  32'(cnt2), 32'h2);
    chk("seq_rdy2",  32'(rdy2), PF ? 32'h1 : 32'h0);

    // Hold FULL for 5 cycles with IValid high and no Consume
    d = 8'hFF;
    repeat (5) tick();
    chk("hold_ir",   32'(ir2),  32'h3412);
    chk("hold_val",  32'(val2), 32'h1);
    chk("hold_cnt",  32'(cnt2), 32'h2);
    chk("hold_rdy",  32'(rdy2), 32'h0);
    v2 = 1'b0; consume = 1'b1;
    tick();
    // With prefetch the shadow (FF,FF) was complete, so it becomes the new instruction.
    chk("cons_val",  32'(val2), PF ? 32'h1 : 32'h0);
    chk("cons_cnt",  32'(cnt2), PF ? 32'h2 : 32'h0);
    chk("cons_ir",   32'(ir2),  PF ? 32'hFFFF : 32'h3412);
    tick();
    // Second Consume: empties the prefetch build; without prefetch it is ignored in FILL.
    chk("cons2_val", 32'(val2), 32'h0);
    chk("cons2_cnt", 32'(cnt2), 32'h0);
    chk("cons2_rdy", 32'(rdy2), 32'h1);
    consume = 1'b0;

    // Prefetch path: complete 0x2211, then offer 0x56,0x78 during FULL
    v2 = 1'b1; d = 8'h11;
    tick();
    d = 8'h22;
    tick();
    chk("pf_ir0",    32'(ir2),  32'h2211);
    chk("pf_rdy",    32'(rdy2), PF ? 32'h1 : 32'h0);
    d = 8'h56;
    tick();
    d = 8'h78;
    tick();
    v2 = 1'b0; consume = 1'b1;
    tick();
    chk("pf_ir1",    32'(ir2),  PF ? 32'h7856 : 32'h2211);
    chk("pf_val",    32'(val2), PF ? 32'h1 : 32'h0);
    chk("pf_cnt",    32'(cnt2), PF ? 32'h2 : 32'h0);
    tick();
    consume = 1'b0;
    chk("pf_val2",   32'(val2), 32'h0);
    chk("pf_cnt2",   32'(cnt2), 32'h0);

    // Flush beats a simultaneous transfer; IROut is left as it was
    v2 = 1'b1; d = 8'hAB;
    tick();
    chk("fl_cnt1",   32'(cnt2), 32'h1);
    flush = 1'b1; d = 8'hCD;
    tick();
    flush = 1'b0; v2 = 1'b0;
    chk("fl_cnt",    32'(cnt2), 32'h0);
    chk("fl_val",    32'(val2), 32'h0);
    chk("fl_rdy",    32'(rdy2), 32'h1);
    chk("fl_ir",     32'(ir2),  PF ? 32'h78AB : 32'h22AB);
    v2 = 1'b1; d = 8'h01;
    tick();
    d = 8'h02;
    tick();
    v2 = 1'b0;
    chk("fl_restart", 32'(ir2), 32'h0201);
    chk("fl_rval",   32'(val2), 32'h1);

    // 4-byte indexed fill, order 3,1,0,2
    mode = 1'b1; v4 = 1'b1;
    sel4 = 2'd3; d = 8'hAA; tick();
    chk("ix_cnt1",   32'(cnt4), 32'h1);
    chk("ix_val1",   32'(val4), 32'h0);
    sel4 = 2'd1; d = 8'hBB; tick();
    chk("ix_cnt2",   32'(cnt4), 32'h2);
    sel4 = 2'd0; d = 8'hCC; tick();
    chk("ix_cnt3",   32'(cnt4), 32'h3);
    sel4 = 2'd2; d = 8'hDD; tick();
    chk("ix_cnt4",   32'(cnt4), 32'h4);
    chk("ix_ir",     32'(ir4),  32'hAADDBBCC);
    chk("ix_val",    32'(val4), 32'h1);
    v4 = 1'b0; consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("ix_cval",   32'(val4), 32'h0);
    chk("ix_ccnt",   32'(cnt4), 32'h0);

    // Overwrite of an already-loaded index, then a sequential byte in the same instruction
    v4 = 1'b1; sel4 = 2'd2; d = 8'h11; tick();
    chk("ow_cnt1",   32'(cnt4), 32'h1);
    d = 8'h22; tick();
    chk("ow_cnt2",   32'(cnt4), 32'h1);
    chk("ow_ir",     32'(ir4),  32'hAA22BBCC);
    mode = 1'b0; d = 8'h33; tick();
    v4 = 1'b0;
    chk("mix_cnt",   32'(cnt4), 32'h2);
    chk("mix_ir",    32'(ir4),  32'hAA22BB33);

    // Asynchronous reset between edges, mid-fill
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt4",   32'(cnt4), 32'h0);
    chk("ar_ir4",    32'(ir4),  32'h0);
    chk("ar_val4",   32'(val4), 32'h0);
    chk("ar_rdy4",   32'(rdy4), 32'h1);
    chk("ar_ir2",    32'(ir2),  32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_after",  32'(cnt4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_register.md
Name: instruction_fetch_register

Overview:
Parametrised instruction register that assembles an instruction of NUM_BYTES bytes, each BYTE_W bits wide, from a byte-wide fetch stream. Each byte is accepted through a valid/ready handshake. Bytes are placed either automatically or by explicit byte index. The block raises IRValid when the instruction is complete and holds it until the decode stage consumes it. It sits between the memory read port and the control unit's decoder.

Parameters:
BYTE_W, 8, width of one fetched byte
NUM_BYTES, 2, bytes per instruction (>=2); IROut width = BYTE_W*NUM_BYTES
IDX_W, $clog2(NUM_BYTES), width of ByteSel (derived, not overridden)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
I  input  BYTE_W  fetched byte
IValid  input  1  I is valid this cycle
IReady  output  1  block can accept a byte
Mode  input  1  0 = sequential placement, 1 = indexed placement
ByteSel  input  IDX_W  target byte index when Mode=1
Consume  input  1  decoder has taken the instruction
Flush  input  1  discard the partial or complete instruction
IROut  output  BYTE_W*NUM_BYTES  assembled instruction; byte 0 = least significant
IRValid  output  1  IROut holds a complete instruction
ByteCount  output  IDX_W+1  number of distinct bytes loaded

Behaviour:
- Reset asserted (Reset=0), asynchronously: IROut=0, IRValid=0, ByteCount=0, load mask=0, state FILL, IReady=1.
- States: FILL (collecting bytes) and FULL (instruction complete). IReady=1 in FILL and 0 in FULL. IReady depends on registered state only, with no combinational path from IValid.
- Transfer: IValid && IReady at a rising Clock edge.
- Mode=0: the byte is written to the lowest-indexed byte whose mask bit is clear.
- Mode=1: the byte is written to index ByteSel.
  - ByteSel>=NUM_BYTES: the transfer is accepted and dropped, with no state change.
  - Rewriting an already-loaded index overwrites the byte; ByteCount is unchanged.
- Every write sets its mask bit. ByteCount = popcount(mask), registered.
- Completion: when a write makes the mask all ones, at that same edge state goes to FULL and IRValid goes to 1. IRValid is first visible the cycle after the last byte edge, i.e. 1-cycle latency.
- FULL: IROut is held stable and IValid is ignored. When Consume=1 at an edge, the next state is FILL with IRValid=0, mask=0 and ByteCount=0. IROut keeps its old contents until overwritten.
- Consume while in FILL is ignored.
- Flush=1 at an edge has the highest priority, over any transfer or Consume in the same cycle. It sets mask=0, ByteCount=0, IRValid=0 and state FILL; IROut is unchanged.
- Reset deasserted mid-instruction: the block restarts from empty, and the partial bytes are lost.
- Mixing modes within one instruction is legal; the mask governs placement.

Optional Feature:
Macro IR_PREFETCH_EN.
- Defined: adds a shadow byte buffer and shadow mask.
  - In FULL, IReady=1 while the shadow mask is not all ones, and transfers fill the shadow under the same placement rules.
  - Consume with a complete shadow (including a shadow completed at the same edge) copies the shadow into IROut and the mask. IRValid stays 1 and the shadow clears.
  - Consume with a partial shadow moves the loaded shadow bytes into IROut and the mask, sets IRValid=0 and state FILL.
  - Flush clears both buffers.
  - ByteCount reports the primary mask only.
- Undefined: there is no shadow storage, and IReady=0 throughout FULL.

Test Plan:
- Reset, then Mode=0 with bytes 0x12 then 0x34, NUM_BYTES=2 -> IROut=0x3412; IRValid=1 the cycle after the 2nd byte; IReady=0; ByteCount=2.
- NUM_BYTES=4, Mode=1, ByteSel order 3,1,0,2 with bytes AA,BB,CC,DD -> IROut=0xAADDBBCC; ByteCount steps 1,2,3,4.
- Complete instruction, hold Consume=0 for 5 cycles while IValid=1 -> IROut and IRValid unchanged, no byte accepted; Consume=1 -> IRValid=0 and ByteCount=0 next cycle.
- One byte loaded, then Flush=1 together with IValid=1 -> byte not accepted; ByteCount=0, IRValid=0.
- Reset=0 asynchronously mid-fill (between edges) -> outputs clear immediately, without a Clock edge.
- IR_PREFETCH_EN: during FULL send 0x56,0x78, then Consume -> IROut=0x7856 and IRValid stays 1 with no gap; without the macro the same stimulus sees IReady=0 and no bytes are accepted.
